// File: rtl/xorshift_prng_if.sv
// xorshift_prng_if: request/seed/result bundle between a requester (master) and the generator (slave)
// Signals: seed_load, seed_in, req (master->slave); busy, valid, rnd_out, count (slave->master)
// count is present only when PRNG_PERIOD_CNT_EN is defined.
interface xorshift_prng_if #(
  parameter int WIDTH = 16
);
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             req;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] rnd_out;
`ifdef PRNG_PERIOD_CNT_EN
  logic [WIDTH-1:0] count;
  modport master (output seed_load, seed_in, req, input busy, valid, rnd_out, count);
  modport slave  (input seed_load, seed_in, req, output busy, valid, rnd_out, count);
`else
  modport master (output seed_load, seed_in, req, input busy, valid, rnd_out);
  modport slave  (input seed_load, seed_in, req, output busy, valid, rnd_out);
`endif
endinterface

// File: rtl/xorshift_prng.sv
// xorshift_prng: xorshift generator, one shift-XOR stage per clock, req/valid handshake
// Ports: clk, rst (async, active-high); bus (xorshift_prng_if.slave): seed_load, seed_in, req,
//   busy, valid, rnd_out, and count when PRNG_PERIOD_CNT_EN is defined.
// A zero seed_in is replaced by SEED so the all-zero lock-up state is never entered.
module xorshift_prng #(
  parameter int               WIDTH   = 16,
  parameter int               SHIFT_A = 7,
  parameter int               SHIFT_B = 9,
  parameter int               SHIFT_C = 8,
  parameter logic [WIDTH-1:0] SEED    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic             clk,
  input logic             rst,
  xorshift_prng_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ST_A, ST_B, ST_C} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, r_rnd, w_seed, w_step;
  logic             r_valid, w_done;
  always_comb begin
    w_seed      = (bus.seed_in == '0) ? SEED : bus.seed_in;
    w_step      = r_state == ST_A ? r_x ^ (r_x << SHIFT_A) :
                  r_state == ST_B ? r_x ^ (r_x >> SHIFT_B) :
                  r_state == ST_C ? r_x ^ (r_x << SHIFT_C) : r_x;
    w_done      = !bus.seed_load && r_state == ST_C;
    w_state_nxt = bus.seed_load    ? IDLE :
                  r_state == IDLE  ? (bus.req ? ST_A : IDLE) :
                  r_state == ST_A  ? ST_B :
                  r_state == ST_B  ? ST_C : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_x     <= SEED;
      r_valid <= 1'b0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= bus.seed_load ? w_seed : w_step;
      r_valid <= w_done;
      if (w_done) r_rnd <= w_step;
    end
  assign bus.busy    = r_state != IDLE;
  assign bus.valid   = r_valid;
  assign bus.rnd_out = r_rnd;
`ifdef PRNG_PERIOD_CNT_EN
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (bus.seed_load) r_count <= '0;
    else if (w_done) r_count <= r_count + 1'b1;
  assign bus.count = r_count;
`endif
endmodule

// File: tb/tb_xorshift_prng.sv
// tb_xorshift_prng: directed scoreboard bench for xorshift_prng (default parameters)
module tb_xorshift_prng;
  typedef struct {
    logic [15:0] w;
    int          cyc;
    logic [15:0] c;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] exp_count = '0;
  exp_t        q[$];
  xorshift_prng_if #(.WIDTH(16)) bus ();
  xorshift_prng #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      chk("valid_single_cycle", int'(prev_valid), 0);
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rnd_out", int'(bus.rnd_out), int'(e.w));
        chk("valid_cycle", cyc, e.cyc);
`ifdef PRNG_PERIOD_CNT_EN
        chk("count", int'(bus.count), int'(e.c));
`endif
      end
    end
    prev_valid = !rst && bus.valid;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] w);
    exp_count++;
    q.push_back('{w, cyc + 4, exp_count});
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask
  task automatic load(input logic [15:0] s);
    bus.seed_load = 1'b1;
    bus.seed_in   = s;
    tick();
    bus.seed_load = 1'b0;
    exp_count     = '0;
  endtask
  initial begin
    int n;
    bus.req       = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
    repeat (2) tick();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_rnd_out", int'(bus.rnd_out), 0);
`ifdef PRNG_PERIOD_CNT_EN
    chk("reset_count", int'(bus.count), 0);
`endif
    rst = 1'b0;
    tick();
    issue(16'h8181);
    chk("busy_edge_n", int'(bus.busy), 1);
    tick();
    chk("busy_edge_n1", int'(bus.busy), 1);
    tick();
    chk("busy_edge_n2", int'(bus.busy), 1);
    tick();
    chk("busy_edge_n3", int'(bus.busy), 0);
    drain();
    issue(16'h6021);
    drain();
    load(16'h0000);
    chk("rnd_held_after_load", int'(bus.rnd_out), 16'h6021);
    issue(16'h8181);
    drain();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    load(16'h0001);
    chk("busy_after_abort", int'(bus.busy), 0);
    repeat (6) tick();
    issue(16'h8181);
    drain();
    bus.req = 1'b1;
    load(16'h0001);
    bus.req = 1'b0;
    chk("busy_load_beats_req", int'(bus.busy), 0);
    n = cyc + 1;
    q.push_back('{16'h8181, n + 3, 16'd1});
    q.push_back('{16'h6021, n + 7, 16'd2});
    q.push_back('{16'hE999, n + 11, 16'd3});
    bus.req = 1'b1;
    repeat (12) tick();
    bus.req = 1'b0;
    drain();
    repeat (4) tick();
    chk("rnd_held_idle", int'(bus.rnd_out), 16'hE999);
    chk("no_extra_valid", q.size(), 0);
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_valid", int'(bus.valid), 0);
    chk("async_rst_rnd_out", int'(bus.rnd_out), 0);
`ifdef PRNG_PERIOD_CNT_EN
    chk("async_rst_count", int'(bus.count), 0);
`endif
    tick();
    rst = 1'b0;
    exp_count = '0;
    tick();
    issue(16'h8181);
    drain();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
